mouse_bus_responder: RTL

Bus-mapped responder sitting on the CPU data bus beside RAM, VGA and timer. It accepts three-byte movement packets from the PS/2 mouse transceiver and accumulates a clamped screen position. It exposes status, X and Y to CPU reads at four consecutive addresses, and raises interrupt line 0 (the mouse slot) on every accepted packet until the CPU acknowledges.

---
 rtl/mouse_bus_responder_if.sv | 24 ++
 rtl/mouse_bus_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/mouse_bus_responder_if.sv
// CPU bus control and PS/2 packet signals shared by the mouse responder.
// BUS_DATA is kept out of this interface and stays a plain inout port on the responder.
interface mouse_bus_responder_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  logic       PKT_VALID;
  logic [7:0] PKT_STATUS;
  logic [7:0] PKT_DX;
  logic [7:0] PKT_DY;

  modport master (
    output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    output PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    input  PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/mouse_bus_responder.sv
// Bus-mapped mouse responder: accumulates clamped X/Y from PS/2 packets,
// exposes STATUS/X/Y/COUNT at four bus addresses and raises the mouse interrupt.
module mouse_bus_responder #(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119,
  parameter int         X_INIT    = 80,
  parameter int         Y_INIT    = 60
) (
  input  logic                        CLK,
  input  logic                        RESET,
  mouse_bus_responder_if.slave        bus,
  inout  wire  [7:0]                  BUS_DATA,
  output logic [7:0]                  MOUSE_X,
  output logic [7:0]                  MOUSE_Y
);

  localparam logic [9:0] X_MAX10 = 10'(X_MAX);
  localparam logic [9:0] Y_MAX10 = 10'(Y_MAX);
  localparam logic [7:0] X_MAX8  = 8'(X_MAX);
  localparam logic [7:0] Y_MAX8  = 8'(Y_MAX);

  logic [7:0] x_reg, y_reg, count_reg;
  logic [2:0] buttons_reg;
  logic       lost_reg, irq_reg;
  logic       rd_en_reg;
  logic [7:0] rd_data_reg;

  logic       in_window, rd_hit, wr_x, wr_y, status_read;
  logic [1:0] offset;
  logic [9:0] dx10, dy10, xn, yn;
  logic [7:0] x_pkt, y_pkt, x_next, y_next, rd_mux;
  logic       lost_next, irq_next;
  logic       status_unused;

  assign status_unused = bus.PKT_STATUS[3];

  // Nine-bit compare keeps the window from wrapping past 8'hFF.
  assign in_window = ({1'b0, bus.BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.BUS_ADDR} <= ({1'b0, BASE_ADDR} + 9'd3));
  assign offset      = bus.BUS_ADDR[1:0] - BASE_ADDR[1:0];
  assign rd_hit      = in_window && !bus.BUS_WE;
  assign wr_x        = in_window && bus.BUS_WE && (offset == 2'd1);
  assign wr_y        = in_window && bus.BUS_WE && (offset == 2'd2);
  assign status_read = rd_hit && (offset == 2'd0);

  // Sign-extended deltas in 10 bits; a negative result shows up in bit 9.
  always_comb begin
    dx10  = bus.PKT_STATUS[6] ? 10'd0 : {{2{bus.PKT_STATUS[4]}}, bus.PKT_DX};
    dy10  = bus.PKT_STATUS[7] ? 10'd0 : {{2{bus.PKT_STATUS[5]}}, bus.PKT_DY};
    xn    = {2'b00, x_reg} + dx10;
    yn    = {2'b00, y_reg} - dy10;
    x_pkt = xn[9] ? 8'd0 : ((xn > X_MAX10) ? X_MAX8 : xn[7:0]);
    y_pkt = yn[9] ? 8'd0 : ((yn > Y_MAX10) ? Y_MAX8 : yn[7:0]);
  end

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (bus.PKT_VALID) begin
      x_next = x_pkt;
      y_next = y_pkt;
    end
    if (wr_x) x_next = (BUS_DATA > X_MAX8) ? X_MAX8 : BUS_DATA;
    if (wr_y) y_next = (BUS_DATA > Y_MAX8) ? Y_MAX8 : BUS_DATA;
  end

  // A new packet beats both the ACK and the LOST-clearing status read.
  always_comb begin
    irq_next  = irq_reg;
    lost_next = lost_reg;
    if (bus.PKT_VALID)              irq_next = 1'b1;
    else if (bus.BUS_INTERRUPT_ACK) irq_next = 1'b0;
    if (bus.PKT_VALID && irq_reg)   lost_next = 1'b1;
    else if (status_read)           lost_next = 1'b0;
  end

  always_comb begin
    rd_mux = 8'd0;
    case (offset)
      2'd0:    rd_mux = {4'd0, lost_reg, buttons_reg};
      2'd1:    rd_mux = x_reg;
      2'd2:    rd_mux = y_reg;
      default: rd_mux = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_reg       <= 8'(X_INIT);
      y_reg       <= 8'(Y_INIT);
      buttons_reg <= 3'd0;
      lost_reg    <= 1'b0;
      count_reg   <= 8'd0;
      irq_reg     <= 1'b0;
      rd_en_reg   <= 1'b0;
      rd_data_reg <= 8'd0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      lost_reg  <= lost_next;
      irq_reg   <= irq_next;
      rd_en_reg <= rd_hit;
      if (rd_hit) rd_data_reg <= rd_mux;
      if (bus.PKT_VALID) begin
        buttons_reg <= bus.PKT_STATUS[2:0];
        count_reg   <= count_reg + 8'd1;
      end
    end
  end

  assign BUS_DATA                = rd_en_reg ? rd_data_reg : 8'hzz;
  assign bus.BUS_INTERRUPT_RAISE = irq_reg;
  assign MOUSE_X                 = x_reg;
  assign MOUSE_Y                 = y_reg;

endmodule
